// File: rtl/clock_time_set_controller.sv
// Manual time-set sequencer: walks hour -> min -> sec on a shadow copy of the
// live time, blinks the field being edited, and pulses a one-cycle load on confirm.
module clock_time_set_controller #(
    parameter int BLINK_HALF = 50_000_000,
    parameter int TIMEOUT    = 1_000_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_min,
    input  logic [5:0] cur_sec,
    output logic [4:0] o_disp_hour,
    output logic [5:0] o_disp_min,
    output logic [5:0] o_disp_sec,
    output logic       o_blank_hour,
    output logic       o_blank_min,
    output logic       o_blank_sec,
    output logic [4:0] o_set_hour,
    output logic [5:0] o_set_min,
    output logic [5:0] o_set_sec,
    output logic       o_load,
    output logic       o_editing
);
    localparam int BW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [BW-1:0] BL_LAST = BW'(BLINK_HALF - 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT} state_t;

    state_t          state_q, state_d;
    logic [4:0]      hour_q, hour_d, set_hour_q, set_hour_d;
    logic [5:0]      min_q, min_d, set_min_q, set_min_d;
    logic [5:0]      sec_q, sec_d, set_sec_q, set_sec_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    logic            phase_q, phase_d;
    logic            blank_hour_q, blank_min_q, blank_sec_q;
    logic            load_q, editing_q;
    logic            btn_any, adj;

    function automatic logic is_edit(input state_t s);
        return (s == EDIT_HOUR) || (s == EDIT_MIN) || (s == EDIT_SEC);
    endfunction

    function automatic logic [4:0] step_hour(input logic [4:0] v, input logic up);
        if (up) return (v >= 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    function automatic logic [5:0] step_60(input logic [5:0] v, input logic up);
        if (up) return (v >= 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    assign btn_any = btn_mode | btn_up | btn_down;
    assign adj     = btn_up ^ btn_down;

    always_comb begin
        state_d    = state_q;
        hour_d     = hour_q;
        min_d      = min_q;
        sec_d      = sec_q;
        set_hour_d = set_hour_q;
        set_min_d  = set_min_q;
        set_sec_d  = set_sec_q;
        unique case (state_q)
            IDLE: if (btn_mode) begin
                state_d = EDIT_HOUR;
                hour_d  = (cur_hour > 5'd23) ? 5'd23 : cur_hour;
                min_d   = (cur_min  > 6'd59) ? 6'd59 : cur_min;
                sec_d   = (cur_sec  > 6'd59) ? 6'd59 : cur_sec;
            end
            EDIT_HOUR, EDIT_MIN, EDIT_SEC: begin
                if (btn_mode) begin
                    state_d = (state_q == EDIT_HOUR) ? EDIT_MIN :
                              (state_q == EDIT_MIN)  ? EDIT_SEC : COMMIT;
                end else if (adj) begin
                    if (state_q == EDIT_HOUR)     hour_d = step_hour(hour_q, btn_up);
                    else if (state_q == EDIT_MIN) min_d  = step_60(min_q, btn_up);
                    else                          sec_d  = step_60(sec_q, btn_up);
                end else if (!btn_any && to_cnt_q == TO_LAST) begin
                    // Abandoned edit: drop the shadows, never load.
                    state_d = IDLE;
                    hour_d  = '0;
                    min_d   = '0;
                    sec_d   = '0;
                end
            end
            COMMIT:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_d == COMMIT) begin
            set_hour_d = hour_q;
            set_min_d  = min_q;
            set_sec_d  = sec_q;
        end

        to_cnt_d = (is_edit(state_q) && is_edit(state_d) && !btn_any) ? to_cnt_q + 1'b1 : '0;

        // Blink restarts visible on field entry and on every adjustment.
        blink_cnt_d = '0;
        phase_d     = 1'b0;
        if (is_edit(state_d) && state_d == state_q && !(btn_up | btn_down)) begin
            if (blink_cnt_q == BL_LAST) begin
                phase_d = ~phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 1'b1;
                phase_d     = phase_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            hour_q       <= '0;
            min_q        <= '0;
            sec_q        <= '0;
            set_hour_q   <= '0;
            set_min_q    <= '0;
            set_sec_q    <= '0;
            blink_cnt_q  <= '0;
            to_cnt_q     <= '0;
            phase_q      <= 1'b0;
            blank_hour_q <= 1'b0;
            blank_min_q  <= 1'b0;
            blank_sec_q  <= 1'b0;
            load_q       <= 1'b0;
            editing_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            hour_q       <= hour_d;
            min_q        <= min_d;
            sec_q        <= sec_d;
            set_hour_q   <= set_hour_d;
            set_min_q    <= set_min_d;
            set_sec_q    <= set_sec_d;
            blink_cnt_q  <= blink_cnt_d;
            to_cnt_q     <= to_cnt_d;
            phase_q      <= phase_d;
            blank_hour_q <= (state_d == EDIT_HOUR) && phase_d;
            blank_min_q  <= (state_d == EDIT_MIN)  && phase_d;
            blank_sec_q  <= (state_d == EDIT_SEC)  && phase_d;
            load_q       <= (state_d == COMMIT);
            editing_q    <= is_edit(state_d);
        end
    end

    assign o_disp_hour  = (state_q == IDLE) ? cur_hour : hour_q;
    assign o_disp_min   = (state_q == IDLE) ? cur_min  : min_q;
    assign o_disp_sec   = (state_q == IDLE) ? cur_sec  : sec_q;
    assign o_blank_hour = blank_hour_q;
    assign o_blank_min  = blank_min_q;
    assign o_blank_sec  = blank_sec_q;
    assign o_set_hour   = set_hour_q;
    assign o_set_min    = set_min_q;
    assign o_set_sec    = set_sec_q;
    assign o_load       = load_q;
    assign o_editing    = editing_q;
endmodule

// File: tb/tb_clock_time_set_controller.sv
// Directed bench for clock_time_set_controller: vector table for the full set/commit
// flow plus hand sequences for wrap, blink, priority, timeout, reset and clamping.
module tb_clock_time_set_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic       btn_mode, btn_up, btn_down;
    logic [4:0] cur_hour;
    logic [5:0] cur_min, cur_sec;
    logic [4:0] o_disp_hour, o_set_hour;
    logic [5:0] o_disp_min, o_disp_sec, o_set_min, o_set_sec;
    logic       o_blank_hour, o_blank_min, o_blank_sec, o_load, o_editing;

    int n_chk  = 0;
    int n_fail = 0;

    clock_time_set_controller #(.BLINK_HALF(4), .TIMEOUT(64)) dut (
        .clk(clk), .rst(rst),
        .btn_mode(btn_mode), .btn_up(btn_up), .btn_down(btn_down),
        .cur_hour(cur_hour), .cur_min(cur_min), .cur_sec(cur_sec),
        .o_disp_hour(o_disp_hour), .o_disp_min(o_disp_min), .o_disp_sec(o_disp_sec),
        .o_blank_hour(o_blank_hour), .o_blank_min(o_blank_min), .o_blank_sec(o_blank_sec),
        .o_set_hour(o_set_hour), .o_set_min(o_set_min), .o_set_sec(o_set_sec),
        .o_load(o_load), .o_editing(o_editing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       m, u, d;
        logic [4:0] hr;
        logic [5:0] mn, sc;
        logic       ed, ld;
        logic [4:0] shr;
        logic [5:0] smn, ssc;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a one-cycle button pulse starting at a negedge; returns at the next negedge.
    task automatic pulse(input logic m, input logic u, input logic d);
        btn_mode = m; btn_up = u; btn_down = d;
        @(negedge clk);
        btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic set_cur(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
        cur_hour = h; cur_min = m; cur_sec = s;
    endtask

    logic ld_seen;

    initial begin
        //         m  u  d  hr     mn     sc     ed ld shr    smn    ssc
        tbl[0]  = '{1, 0, 0, 5'd10, 6'd20, 6'd30, 1, 0, 5'd0,  6'd0,  6'd0};
        tbl[1]  = '{0, 1, 0, 5'd11, 6'd20, 6'd30, 1, 0, 5'd0,  6'd0,  6'd0};
        tbl[2]  = '{0, 1, 0, 5'd12, 6'd20, 6'd30, 1, 0, 5'd0,  6'd0,  6'd0};
        tbl[3]  = '{1, 0, 0, 5'd12, 6'd20, 6'd30, 1, 0, 5'd0,  6'd0,  6'd0};
        tbl[4]  = '{0, 0, 1, 5'd12, 6'd19, 6'd30, 1, 0, 5'd0,  6'd0,  6'd0};
        tbl[5]  = '{1, 0, 0, 5'd12, 6'd19, 6'd30, 1, 0, 5'd0,  6'd0,  6'd0};
        tbl[6]  = '{0, 1, 0, 5'd12, 6'd19, 6'd31, 1, 0, 5'd0,  6'd0,  6'd0};
        tbl[7]  = '{0, 1, 0, 5'd12, 6'd19, 6'd32, 1, 0, 5'd0,  6'd0,  6'd0};
        tbl[8]  = '{0, 1, 0, 5'd12, 6'd19, 6'd33, 1, 0, 5'd0,  6'd0,  6'd0};
        tbl[9]  = '{1, 0, 0, 5'd12, 6'd19, 6'd33, 0, 1, 5'd12, 6'd19, 6'd33};
        tbl[10] = '{0, 0, 0, 5'd10, 6'd20, 6'd30, 0, 0, 5'd12, 6'd19, 6'd33};
        tbl[11] = '{0, 0, 0, 5'd10, 6'd20, 6'd30, 0, 0, 5'd12, 6'd19, 6'd33};

        rst = 1'b1; btn_mode = 1'b0; btn_up = 1'b0; btn_down = 1'b0;
        set_cur(5'd0, 6'd0, 6'd0);
        @(negedge clk);
        chk("reset_state", {o_disp_hour, o_disp_min, o_disp_sec, o_blank_hour, o_blank_min,
            o_blank_sec, o_set_hour, o_set_min, o_set_sec, o_load, o_editing}, 64'd0);
        rst = 1'b0;

        // Full set and commit, table-driven
        set_cur(5'd10, 6'd20, 6'd30);
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            pulse(tbl[i].m, tbl[i].u, tbl[i].d);
            chk($sformatf("vec%0d", i),
                {o_disp_hour, o_disp_min, o_disp_sec, o_editing, o_load, o_set_hour, o_set_min, o_set_sec},
                {tbl[i].hr, tbl[i].mn, tbl[i].sc, tbl[i].ed, tbl[i].ld, tbl[i].shr, tbl[i].smn, tbl[i].ssc});
        end
        set_cur(5'd11, 6'd0, 6'd0);
        #1 chk("idle_follow", {o_disp_hour, o_disp_min, o_disp_sec}, {5'd11, 6'd0, 6'd0});
        @(negedge clk);

        // Entry and hour wrap 23 -> 0
        set_cur(5'd23, 6'd59, 6'd58);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("hour_wrap", {o_disp_hour, o_disp_min, o_editing, o_load}, {5'd0, 6'd59, 1'b1, 1'b0});
        do_reset();

        // Min wrap down, sec wrap up
        set_cur(5'd5, 6'd0, 6'd59);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        pulse(0, 0, 1);
        chk("min_wrap", o_disp_min, 6'd59);
        pulse(1, 0, 0);
        pulse(0, 1, 0);
        chk("sec_wrap", {o_disp_hour, o_disp_min, o_disp_sec}, {5'd5, 6'd59, 6'd0});

        // Timeout: 64 idle cycles in EDIT_SEC
        ld_seen = 1'b0;
        repeat (63) begin
            @(negedge clk);
            ld_seen |= o_load;
        end
        chk("pre_timeout_edit", o_editing, 1'b1);
        @(negedge clk);
        ld_seen |= o_load;
        chk("timeout_idle", {o_editing, o_disp_hour, o_disp_min, o_disp_sec},
            {1'b0, 5'd5, 6'd0, 6'd59});
        chk("timeout_no_load", ld_seen, 1'b0);

        // Blink in EDIT_MIN: 4 visible, 4 hidden, ...
        set_cur(5'd1, 6'd2, 6'd3);
        pulse(1, 0, 0);
        pulse(1, 0, 0);
        for (int k = 0; k <= 12; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("blink%0d", k), {o_blank_hour, o_blank_min, o_blank_sec},
                {1'b0, ((k / 4) % 2) == 1, 1'b0});
        end
        pulse(0, 1, 0);
        chk("blink_restart", {o_blank_min, o_disp_min}, {1'b0, 6'd3});

        // Priority: mode beats up; up+down is a no-op
        do_reset();
        set_cur(5'd7, 6'd8, 6'd9);
        pulse(1, 0, 0);
        pulse(1, 1, 0);
        chk("mode_wins", o_disp_hour, 5'd7);
        pulse(0, 1, 0);
        chk("in_edit_min", {o_disp_hour, o_disp_min}, {5'd7, 6'd9});
        pulse(0, 1, 1);
        chk("up_down_nop", {o_disp_hour, o_disp_min, o_disp_sec, o_editing},
            {5'd7, 6'd9, 6'd9, 1'b1});

        // Async reset mid-edit, while the minute field is hidden
        repeat (4) @(negedge clk);
        chk("pre_rst_blank", o_blank_min, 1'b1);
        #2 rst = 1'b1;
        #1 chk("rst_async", {o_editing, o_load, o_blank_hour, o_blank_min, o_blank_sec,
            o_set_hour, o_set_min, o_set_sec, o_disp_hour, o_disp_min, o_disp_sec},
            {5'b0, 5'd0, 6'd0, 6'd0, 5'd7, 6'd8, 6'd9});
        @(negedge clk);
        chk("rst_hold_no_load", {o_load, o_editing}, 2'b00);
        rst = 1'b0;

        // Out-of-range capture is clamped
        set_cur(5'd25, 6'd63, 6'd0);
        @(negedge clk);
        pulse(1, 0, 0);
        chk("clamp", {o_disp_hour, o_disp_min, o_disp_sec}, {5'd23, 6'd59, 6'd0});

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/clock_time_set_controller.md
Name: clock_time_set_controller

Overview:
- Sequences manual time-setting of the hour/min/sec clock counter that feeds the 4-digit FND controller.
- Holds a shadow copy of the time, steps the user through hour, then minute, then second fields using up/down buttons, and blinks the field being edited.
- On confirm, issues a one-cycle load to the clock counter.
- Sits between the debounced button block, the clock counter and the FND controller's hour/min/sec inputs.

Parameters:
- BLINK_HALF, 50_000_000, clk cycles per blink half-period (0.5 s at 100 MHz).
- TIMEOUT, 1_000_000_000, idle clk cycles in an edit state before the edit is aborted (10 s).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- btn_mode  in  1  single-cycle pulse: enter edit / next field / confirm
- btn_up  in  1  single-cycle pulse: increment current field
- btn_down  in  1  single-cycle pulse: decrement current field
- cur_hour  in  5  live hour from clock counter, 0..23
- cur_min  in  6  live minute, 0..59
- cur_sec  in  6  live second, 0..59
- o_disp_hour  out  5  hour to FND controller
- o_disp_min  out  6  minute to FND controller
- o_disp_sec  out  6  second to FND controller
- o_blank_hour  out  1  1 = FND blanks the hour digits
- o_blank_min  out  1  1 = FND blanks the minute digits
- o_blank_sec  out  1  1 = FND blanks the second digits
- o_set_hour  out  5  hour value to load
- o_set_min  out  6  minute value to load
- o_set_sec  out  6  second value to load
- o_load  out  1  one-cycle load strobe to the clock counter
- o_editing  out  1  1 while in any EDIT state

Behaviour:
- Reset (async) forces:
  - state IDLE
  - shadow registers 0
  - all outputs 0
  - blink phase = visible
  - blink and timeout counters 0
- States: IDLE, EDIT_HOUR, EDIT_MIN, EDIT_SEC, COMMIT.
- IDLE:
  - o_disp_* = cur_* (combinational pass-through); blanks 0; o_editing 0.
  - btn_mode captures cur_* into the shadows and moves to EDIT_HOUR.
  - btn_up and btn_down are ignored.
- EDIT_x:
  - o_disp_* = shadows; o_editing 1.
  - btn_mode moves EDIT_HOUR->EDIT_MIN->EDIT_SEC->COMMIT.
  - btn_up increments the field: hour wraps 23->0; min and sec wrap 59->0.
  - btn_down decrements the field: hour wraps 0->23; min and sec wrap 0->59.
  - Update is visible on o_disp the cycle after the pulse.
- Priority within one cycle:
  - btn_mode wins over up/down; up/down are discarded that cycle.
  - up and down together produce no change but still count as activity.
- COMMIT (exactly 1 cycle):
  - o_set_* = shadows; o_load = 1; then IDLE.
  - o_set_* hold their values after the load; o_load is 0 in every other state.
- Blink:
  - Blink counter runs only in EDIT states and toggles the phase every BLINK_HALF cycles.
  - o_blank_<field> = 1 only for the field being edited, and only while phase = hidden.
  - Entering an EDIT state, or any up/down pulse, resets the counter to 0 and the phase to visible.
  - All blanks are 0 outside EDIT states.
- Timeout:
  - Counter clears on any button pulse and on entry to EDIT_HOUR.
  - Reaching TIMEOUT-1 in an EDIT state jumps to IDLE with no load; shadows are discarded.
- Fields are never written to out-of-range values.
  - Shadow capture of out-of-range cur_* (e.g. hour 25) is clamped to the maximum legal value.
- Reset mid-edit: immediate return to IDLE; no o_load pulse.
- Outputs other than the IDLE pass-through of o_disp_* are registered.

Test Plan:
- Bench parameters BLINK_HALF=4, TIMEOUT=64 for all scenarios.
- Entry and hour wrap: cur=23:59:58; mode, up -> o_disp_hour=0, o_editing=1, o_disp_min=59, no o_load.
- Full set and commit: cur=10:20:30; mode, up x2, mode, down, mode, up x3, mode -> single o_load pulse, o_set=12:19:33; then IDLE with o_disp following cur.
- Min/sec wrap: cur=05:00:59; in EDIT_MIN apply down -> min=59; in EDIT_SEC apply up -> sec=0.
- Blink:
  - In EDIT_MIN, o_blank_min toggles every 4 cycles; o_blank_hour and o_blank_sec stay 0.
  - An up pulse on the cycle the phase is hidden forces o_blank_min=0 next cycle.
- Priority and simultaneity:
  - mode+up in the same cycle in EDIT_HOUR -> EDIT_MIN, hour unchanged.
  - up+down together -> no change.
- Timeout and reset:
  - No buttons for 64 cycles in EDIT_SEC -> IDLE, o_load never asserted.
  - rst asserted in EDIT_MIN -> all outputs 0 and IDLE at once.
  - Out-of-range cur_hour=25 captured -> shadow hour 23.
